// File: rtl/idli_fetch_q_m_if.sv
`default_nettype none
// ============================================================================
// Module      : idli_fetch_q_m_if
// Description : Bundle between the SQI memory front end / execute stage and
//               the instruction fetch queue.
//               Inputs to the queue: phase counter, instruction word + valid,
//               redirect request + new PC, pop from decode.
//               Outputs from the queue: head instruction/PC/valid, stall,
//               occupancy count, sticky overflow flag.
//               master : the driving side (SQI interface, execute, decode)
//               slave  : the fetch queue
// Revision    : 1.0 - initial release
// ============================================================================
interface idli_fetch_q_m_if #(
  parameter int DEPTH = 2,
  parameter int PC_W  = 16
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [1:0]       i_fq_ctr;
  logic [15:0]      i_fq_instr;
  logic             i_fq_instr_vld;
  logic             i_fq_redirect;
  logic [PC_W-1:0]  i_fq_redirect_pc;
  logic             i_fq_pop;

  logic [15:0]      o_fq_instr;
  logic [PC_W-1:0]  o_fq_pc;
  logic             o_fq_vld;
  logic             o_fq_stall;
  logic [CNT_W-1:0] o_fq_count;
  logic             o_fq_ovf;

  modport master (
    output i_fq_ctr, i_fq_instr, i_fq_instr_vld, i_fq_redirect,
           i_fq_redirect_pc, i_fq_pop,
    input  o_fq_instr, o_fq_pc, o_fq_vld, o_fq_stall, o_fq_count, o_fq_ovf
  );

  modport slave (
    input  i_fq_ctr, i_fq_instr, i_fq_instr_vld, i_fq_redirect,
           i_fq_redirect_pc, i_fq_pop,
    output o_fq_instr, o_fq_pc, o_fq_vld, o_fq_stall, o_fq_count, o_fq_ovf
  );
endinterface
`default_nettype wire

// File: rtl/idli_fetch_q_m.sv
`default_nettype none
// ============================================================================
// Module      : idli_fetch_q_m
// Description : Instruction fetch queue behind the SQI memory interface.
//               Captures each 16b instruction word at the end of a 4-GCK
//               period, tags it with its word address and buffers it for
//               decode. Stalls the SQI interface when full, flushes and
//               reloads the fetch PC on redirect.
// Ports       : i_fq_gck - core clock
//               i_fq_rst - asynchronous active-high reset
//               fq       - slave side of idli_fetch_q_m_if (handshakes,
//                          head entry, stall, count, overflow)
// Revision    : 1.0 - initial release
// ============================================================================
module idli_fetch_q_m #(
  parameter int DEPTH = 2,
  parameter int PC_W  = 16
) (
  input  wire logic       i_fq_gck,
  input  wire logic       i_fq_rst,
  idli_fetch_q_m_if.slave fq
);
  localparam int                   PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                   CNT_W      = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]     C_FULL     = CNT_W'(DEPTH);
  localparam logic [1:0]           C_LAST_PH  = 2'd3;

  // Entry storage (not reset; outputs are masked while empty)
  logic [15:0]      instr_mem [DEPTH];
  logic [PC_W-1:0]  pc_mem    [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [PC_W-1:0]  fpc_q;
  logic             ovf;

  logic boundary;
  logic redirect_acc;
  logic pop_acc;
  logic push_acc;
  logic ovf_evt;
  logic full;
  logic not_empty;

  assign full      = (count == C_FULL);
  assign not_empty = (count != '0);
  assign boundary  = (fq.i_fq_ctr == C_LAST_PH);

  // Redirect outranks both push and pop on the same boundary
  assign redirect_acc = boundary & fq.i_fq_redirect;
  assign pop_acc      = boundary & fq.i_fq_pop & not_empty & ~fq.i_fq_redirect;
  // A full queue can still accept a word if the head leaves in the same cycle
  assign push_acc     = boundary & fq.i_fq_instr_vld & ~fq.i_fq_redirect &
                        (~full | pop_acc);
  assign ovf_evt      = boundary & fq.i_fq_instr_vld & ~fq.i_fq_redirect &
                        full & ~pop_acc;

  always_ff @(posedge i_fq_gck or posedge i_fq_rst) begin
    if (i_fq_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      fpc_q  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (redirect_acc) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        fpc_q  <= fq.i_fq_redirect_pc;
      end else begin
        if (pop_acc) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        if (push_acc) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
          fpc_q  <= fpc_q + PC_W'(1);
        end
        if (push_acc && !pop_acc) begin
          count <= count + CNT_W'(1);
        end else if (pop_acc && !push_acc) begin
          count <= count - CNT_W'(1);
        end
      end
      if (ovf_evt) begin
        ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_fq_gck) begin
    if (push_acc) begin
      instr_mem[wr_ptr] <= fq.i_fq_instr;
      pc_mem[wr_ptr]    <= fpc_q;
    end
  end

  // Head read is combinational; everything it depends on is registered and
  // only changes on period boundaries, so it is stable for a whole period.
  assign fq.o_fq_vld   = not_empty;
  assign fq.o_fq_instr = not_empty ? instr_mem[rd_ptr] : 16'h0000;
  assign fq.o_fq_pc    = not_empty ? pc_mem[rd_ptr]    : '0;
  assign fq.o_fq_stall = full;
  assign fq.o_fq_count = count;
  assign fq.o_fq_ovf   = ovf;

endmodule
`default_nettype wire

// File: tb/tb_idli_fetch_q_m.sv
`default_nettype none
// ============================================================================
// Module      : tb_idli_fetch_q_m
// Description : Directed self-checking bench for idli_fetch_q_m (DEPTH=2,
//               PC_W=16). Drives whole 4-GCK periods with requests held for
//               the full period and checks the head entry and status after
//               each boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_idli_fetch_q_m;
  localparam int DEPTH = 2;
  localparam int PC_W  = 16;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  idli_fetch_q_m_if #(.DEPTH(DEPTH), .PC_W(PC_W)) fq ();

  idli_fetch_q_m #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .i_fq_gck (clk),
    .i_fq_rst (rst),
    .fq       (fq.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] instr,
                           input logic [15:0] pc, input logic vld,
                           input logic [1:0] cnt, input logic stall,
                           input logic ovf);
    check({tag, ".instr"}, 32'(fq.o_fq_instr), 32'(instr));
    check({tag, ".pc"},    32'(fq.o_fq_pc),    32'(pc));
    check({tag, ".vld"},   32'(fq.o_fq_vld),   32'(vld));
    check({tag, ".count"}, 32'(fq.o_fq_count), 32'(cnt));
    check({tag, ".stall"}, 32'(fq.o_fq_stall), 32'(stall));
    check({tag, ".ovf"},   32'(fq.o_fq_ovf),   32'(ovf));
  endtask

  // One full period; requests are held for all four phases so only the
  // boundary phase may act on them.
  task automatic period(input logic vld, input logic [15:0] instr,
                        input logic pop, input logic redir,
                        input logic [15:0] rpc);
    fq.i_fq_instr_vld   = vld;
    fq.i_fq_instr       = instr;
    fq.i_fq_pop         = pop;
    fq.i_fq_redirect    = redir;
    fq.i_fq_redirect_pc = rpc;
    for (int k = 0; k < 4; k++) begin
      fq.i_fq_ctr = 2'(k);
      @(posedge clk);
      #1;
    end
    fq.i_fq_instr_vld   = 1'b0;
    fq.i_fq_pop         = 1'b0;
    fq.i_fq_redirect    = 1'b0;
    fq.i_fq_instr       = 16'h0000;
    fq.i_fq_redirect_pc = 16'h0000;
    fq.i_fq_ctr         = 2'd0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst                 = 1'b1;
    fq.i_fq_ctr         = 2'd0;
    fq.i_fq_instr       = 16'h0000;
    fq.i_fq_instr_vld   = 1'b0;
    fq.i_fq_redirect    = 1'b0;
    fq.i_fq_redirect_pc = 16'h0000;
    fq.i_fq_pop         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 16'h0000, 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: fill the queue
    period(1'b1, 16'hA001, 1'b0, 1'b0, 16'h0);
    check_all("push1", 16'hA001, 16'h0000, 1'b1, 2'd1, 1'b0, 1'b0);
    period(1'b1, 16'hA002, 1'b0, 1'b0, 16'h0);
    check_all("push2", 16'hA001, 16'h0000, 1'b1, 2'd2, 1'b1, 1'b0);

    // 2: push+pop while full
    period(1'b1, 16'hB003, 1'b1, 1'b0, 16'h0);
    check_all("pushpop_full", 16'hA002, 16'h0001, 1'b1, 2'd2, 1'b1, 1'b0);

    // 3: overflow drops the word, fpc unchanged
    period(1'b1, 16'hC004, 1'b0, 1'b0, 16'h0);
    check_all("ovf", 16'hA002, 16'h0001, 1'b1, 2'd2, 1'b1, 1'b1);
    period(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0);
    check_all("pop_tail", 16'hB003, 16'h0002, 1'b1, 2'd1, 1'b0, 1'b1);
    period(1'b1, 16'hD005, 1'b0, 1'b0, 16'h0);
    period(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0);
    check_all("fpc_kept", 16'hD005, 16'h0003, 1'b1, 2'd1, 1'b0, 1'b1);
    period(1'b1, 16'hE006, 1'b0, 1'b0, 16'h0);
    check("two_entries.count", 32'(fq.o_fq_count), 32'd2);

    // 4: redirect beats concurrent push and pop
    period(1'b1, 16'hF007, 1'b1, 1'b1, 16'h1234);
    check_all("redirect", 16'h0000, 16'h0000, 1'b0, 2'd0, 1'b0, 1'b1);
    period(1'b1, 16'h1111, 1'b0, 1'b0, 16'h0);
    check_all("redir_push1", 16'h1111, 16'h1234, 1'b1, 2'd1, 1'b0, 1'b1);
    period(1'b1, 16'h2222, 1'b1, 1'b0, 16'h0);
    check_all("pushpop_cnt1", 16'h2222, 16'h1235, 1'b1, 2'd1, 1'b0, 1'b1);

    // 5: PC wrap
    period(1'b0, 16'h0000, 1'b0, 1'b1, 16'hFFFF);
    check("redir_ffff.count", 32'(fq.o_fq_count), 32'd0);
    period(1'b1, 16'h3333, 1'b0, 1'b0, 16'h0);
    check_all("wrap_push1", 16'h3333, 16'hFFFF, 1'b1, 2'd1, 1'b0, 1'b1);
    period(1'b1, 16'h4444, 1'b0, 1'b0, 16'h0);
    period(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0);
    check_all("wrap_push2", 16'h4444, 16'h0000, 1'b1, 2'd1, 1'b0, 1'b1);

    // Off-boundary requests have no effect
    fq.i_fq_ctr         = 2'd1;
    fq.i_fq_instr       = 16'h9999;
    fq.i_fq_instr_vld   = 1'b1;
    fq.i_fq_pop         = 1'b1;
    fq.i_fq_redirect    = 1'b1;
    fq.i_fq_redirect_pc = 16'h5555;
    @(posedge clk);
    #1;
    fq.i_fq_instr_vld   = 1'b0;
    fq.i_fq_pop         = 1'b0;
    fq.i_fq_redirect    = 1'b0;
    fq.i_fq_ctr         = 2'd2;
    @(posedge clk);
    #1;
    check_all("off_boundary", 16'h4444, 16'h0000, 1'b1, 2'd1, 1'b0, 1'b1);

    // 6: asynchronous reset mid-period, checked before any clock edge
    fq.i_fq_ctr = 2'd1;
    #1;
    rst = 1'b1;
    #1;
    check_all("async_rst", 16'h0000, 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    period(1'b1, 16'h5A5A, 1'b0, 1'b0, 16'h0);
    check_all("post_rst_push", 16'h5A5A, 16'h0000, 1'b1, 2'd1, 1'b0, 1'b0);
    period(1'b1, 16'h6B6B, 1'b0, 1'b0, 16'h0);
    period(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0);
    check_all("post_rst_pc1", 16'h6B6B, 16'h0001, 1'b1, 2'd1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Safety net so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire

// File: doc/idli_fetch_q_m.md
Name: idli_fetch_q_m

Overview:
Instruction fetch queue directly downstream of the SQI memory interface.
- Captures each 16b instruction word the SQI interface presents at the end of a 4-GCK DATA period.
- Tags each word with its word address (PC) and holds it in a small FIFO until the decode/execute stage consumes it.
- Asserts stall back to the SQI interface when full, which freezes SCK.
- Flushes the queue and reloads the fetch PC on redirect (branch/load/store).

Parameters:
DEPTH, 2, number of queue entries; power of two, >= 2.
PC_W, 16, width of the word address.

Ports:
i_fq_gck  input  1  core clock (GCK).
i_fq_rst  input  1  reset; asynchronous, active-high.
i_fq_ctr  input  2 (ctr_t)  free-running GCK phase counter; 3 marks the last cycle of a 4-GCK period.
i_fq_instr  input  16 (data_t)  instruction word from the SQI interface.
i_fq_instr_vld  input  1  i_fq_instr is complete this cycle.
i_fq_redirect  input  1  flush request from execute.
i_fq_redirect_pc  input  PC_W  new fetch word address.
i_fq_pop  input  1  decode consumes the head entry.
o_fq_instr  output  16  head entry instruction.
o_fq_pc  output  PC_W  head entry word address.
o_fq_vld  output  1  head entry valid (occupancy != 0).
o_fq_stall  output  1  stall to the SQI interface.
o_fq_count  output  $clog2(DEPTH+1)  occupancy.
o_fq_ovf  output  1  sticky overflow error flag.

Behaviour:
- Reset (async, i_fq_rst=1): all of the following clear and are held while reset is asserted.
  - Occupancy, read/write pointers, fetch PC (fpc_q), o_fq_ovf: 0.
  - o_fq_vld, o_fq_stall: 0; o_fq_count: 0.
  - o_fq_instr, o_fq_pc: 0.
  - Entry storage needs no reset; the outputs are muxed to 0 when the queue is empty.
- Period boundary: all queue state changes only on cycles where i_fq_ctr == 3 (the "boundary").
  - i_fq_instr_vld or i_fq_pop asserted off-boundary is ignored.
- Push accepted when all hold: boundary, i_fq_instr_vld, !i_fq_redirect, and (count < DEPTH or pop accepted this cycle).
  - Write entry {i_fq_instr, fpc_q} at the write pointer.
  - fpc_q increments by 1, wrapping 2^PC_W-1 -> 0.
- Pop accepted when all hold: boundary, i_fq_pop, o_fq_vld, !i_fq_redirect.
  - Advance the read pointer.
  - Pop while empty is ignored and is not an error.
- Simultaneous push and pop:
  - Count is unchanged; this is legal when full.
  - When count == 1, the popped entry leaves and the new word becomes the head in the next cycle.
- Overflow: boundary, i_fq_instr_vld, count == DEPTH, no pop accepted, no redirect.
  - The word is dropped and fpc_q is unchanged.
  - o_fq_ovf sets and stays set until reset.
- Redirect (takes effect on the boundary; priority over push and pop):
  - Count and pointers clear.
  - fpc_q <= i_fq_redirect_pc.
  - Any concurrent instr_vld or pop is discarded.
- Redirect off-boundary is ignored; execute holds it until the boundary.
- Pointers are log2(DEPTH) bits and wrap naturally.
- Count is a separate register, so full and empty are unambiguous.
- o_fq_stall = (count == DEPTH), driven from registered state only (glitch-free).
  - Takes effect one cycle after the boundary that filled the queue.
  - Drops one cycle after the boundary that popped.
- Latency: a word pushed on a boundary appears at o_fq_instr/o_fq_pc with o_fq_vld=1 on the next cycle.
- Outputs are combinational reads of the head entry. They are stable for the whole period, since state changes only on boundaries.

Test Plan:
1. Reset, then push words 0xA001, 0xA002 on consecutive boundaries, no pop.
   - Expect head 0xA001/pc 0x0000, count 2, o_fq_stall=1 on the cycle after the second push.
2. Full (DEPTH=2); push 0xB003 with pop on the same boundary.
   - Expect count stays 2, head becomes 0xA002/pc 0x0001, tail pc 0x0002, o_fq_ovf=0.
3. Full, push 0xC004 with no pop.
   - Expect the word is dropped, o_fq_ovf=1 sticky, fpc_q unchanged, contents unchanged.
4. Two entries; redirect with pc 0x1234, push and pop asserted on the same boundary.
   - Expect count 0, o_fq_vld=0, o_fq_stall=0.
   - Next push is tagged 0x1234; the following push is tagged 0x1235.
5. Redirect pc 0xFFFF, then push twice.
   - Expect pcs 0xFFFF then 0x0000.
   - Separately, pulse instr_vld/pop with i_fq_ctr=1: expect no state change.
6. Assert i_fq_rst asynchronously mid-period with 1 entry held and o_fq_ovf=1.
   - Expect all outputs 0 immediately, without waiting for a clock edge.
   - Expect normal pushes resume at pc 0 after reset deasserts.
